// File: rtl/pc_unit.sv
// 6502 program counter: PCL/PCH registers, vector-fetch sequencer,
// relative-branch adder with page-cross fixup and pending-NMI latch.
module pc_unit #(
    parameter int unsigned         AW       = 16,
    parameter int unsigned         DW       = 8,
    parameter logic [AW-1:0]       VEC_NMI  = 'hFFFA,
    parameter logic [AW-1:0]       VEC_RST  = 'hFFFC,
    parameter logic [AW-1:0]       VEC_IRQ  = 'hFFFE,
    parameter logic [AW-DW-1:0]    STK_PAGE = 'h01
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DW-1:0]      adl_in,
    input  logic [AW-DW-1:0]   adh_in,
    input  logic               adl_wa,
    input  logic               adh_wa,
    input  logic               pc_inc,
    input  logic               br_en,
    input  logic [DW-1:0]      br_off,
    input  logic               vec_rst,
    input  logic               vec_nmi,
    input  logic               vec_irq,
    input  logic [DW-1:0]      db_in,
    input  logic               setstk,
    input  logic               adloa,
    input  logic               adhoa,
    input  logic               dboa_l,
    input  logic               dboa_h,
    output logic [DW-1:0]      adl_out,
    output logic [AW-DW-1:0]   adh_out,
    output logic [DW-1:0]      db_out,
    output logic [AW-1:0]      pc,
    output logic [AW-1:0]      vec_addr,
    output logic               vec_rd,
    output logic               busy,
    output logic               br_fix
);

    localparam int unsigned HW = AW - DW;

    typedef enum logic [1:0] {IDLE, VEC_LO, VEC_HI, BR_FIX} state_t;
    typedef enum logic [1:0] {VS_RST, VS_NMI, VS_IRQ} vsel_t;

    state_t          state, state_nx;
    vsel_t           vsel, vsel_nx;
    logic [DW-1:0]   pcl, pcl_nx;
    logic [HW-1:0]   pch, pch_nx;
    logic            nmi_pend, nmi_pend_nx;
    logic            br_dir, br_dir_nx;
    logic [DW:0]     br_sum;
    logic [AW-1:0]   pc_plus1;
    logic [AW-1:0]   vec_base;

    // Sign-extended offset into DW+1 bits: bit DW flags a carry or borrow out of PCL.
    assign br_sum   = {1'b0, pcl} + {br_off[DW-1], br_off};
    assign pc_plus1 = {pch, pcl} + AW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= VEC_LO;
            vsel     <= VS_RST;
            pcl      <= '0;
            pch      <= '0;
            nmi_pend <= 1'b0;
            br_dir   <= 1'b0;
        end else begin
            state    <= state_nx;
            vsel     <= vsel_nx;
            pcl      <= pcl_nx;
            pch      <= pch_nx;
            nmi_pend <= nmi_pend_nx;
            br_dir   <= br_dir_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        vsel_nx     = vsel;
        pcl_nx      = pcl;
        pch_nx      = pch;
        nmi_pend_nx = nmi_pend;
        br_dir_nx   = br_dir;

        case (state)
            IDLE: begin
                if (vec_rst) begin
                    state_nx = VEC_LO;
                    vsel_nx  = VS_RST;
                end else if (nmi_pend || vec_nmi) begin
                    state_nx    = VEC_LO;
                    vsel_nx     = VS_NMI;
                    nmi_pend_nx = 1'b0;
                end else if (vec_irq) begin
                    state_nx = VEC_LO;
                    vsel_nx  = VS_IRQ;
                end else if (adl_wa || adh_wa) begin
                    if (adl_wa) pcl_nx = adl_in;
                    if (adh_wa) pch_nx = adh_in;
                end else if (br_en) begin
                    pcl_nx = br_sum[DW-1:0];
                    if (br_sum[DW]) begin
                        state_nx  = BR_FIX;
                        br_dir_nx = br_off[DW-1];
                    end
                end else if (pc_inc) begin
                    {pch_nx, pcl_nx} = pc_plus1;
                end
            end
            VEC_LO: begin
                pcl_nx   = db_in;
                state_nx = VEC_HI;
            end
            VEC_HI: begin
                pch_nx   = HW'(db_in);
                state_nx = IDLE;
            end
            BR_FIX: begin
                pch_nx   = br_dir ? pch - HW'(1) : pch + HW'(1);
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase

        // Busy cycles only honour a reset restart and latch NMI for later.
        if (state != IDLE) begin
            if (vec_nmi) nmi_pend_nx = 1'b1;
            if (vec_rst) begin
                state_nx = VEC_LO;
                vsel_nx  = VS_RST;
                pcl_nx   = pcl;
                pch_nx   = pch;
            end
        end
    end

    always_comb begin
        case (vsel)
            VS_NMI:  vec_base = VEC_NMI;
            VS_IRQ:  vec_base = VEC_IRQ;
            default: vec_base = VEC_RST;
        endcase
    end

    assign pc       = {pch, pcl};
    assign busy     = (state != IDLE);
    assign br_fix   = (state == BR_FIX);
    assign vec_rd   = (state == VEC_LO) || (state == VEC_HI);
    assign vec_addr = (state == VEC_LO) ? vec_base :
                      (state == VEC_HI) ? vec_base + AW'(1) : '0;

    // Bus drivers; setstk and dboa_l win so each bus has a single source.
    assign adl_out = adloa  ? pcl : {DW{1'bz}};
    assign adh_out = setstk ? STK_PAGE : (adhoa ? pch : {HW{1'bz}});
    assign db_out  = dboa_l ? pcl : (dboa_h ? DW'(pch) : {DW{1'bz}});

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: directed scenarios then random traffic,
// checked against a behavioural PC model.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  adl_in, adh_in, br_off, db_in;
    logic        adl_wa, adh_wa, pc_inc, br_en;
    logic        vec_rst, vec_nmi, vec_irq;
    logic        setstk, adloa, adhoa, dboa_l, dboa_h;
    logic [7:0]  adl_out, adh_out, db_out;
    logic [15:0] pc, vec_addr;
    logic        vec_rd, busy, br_fix;

    always #5 clk = ~clk;

    pc_unit dut (
        .clk(clk), .rst(rst),
        .adl_in(adl_in), .adh_in(adh_in), .adl_wa(adl_wa), .adh_wa(adh_wa),
        .pc_inc(pc_inc), .br_en(br_en), .br_off(br_off),
        .vec_rst(vec_rst), .vec_nmi(vec_nmi), .vec_irq(vec_irq), .db_in(db_in),
        .setstk(setstk), .adloa(adloa), .adhoa(adhoa), .dboa_l(dboa_l), .dboa_h(dboa_h),
        .adl_out(adl_out), .adh_out(adh_out), .db_out(db_out),
        .pc(pc), .vec_addr(vec_addr), .vec_rd(vec_rd), .busy(busy), .br_fix(br_fix)
    );

    typedef struct {
        logic       rst, adl_wa, adh_wa, pc_inc, br_en;
        logic       vec_rst, vec_nmi, vec_irq;
        logic       setstk, adloa, adhoa, dboa_l, dboa_h;
        logic [7:0] adl, adh, off, db;
    } stim_t;

    typedef struct {
        int         id;
        logic [15:0] pc, vaddr;
        logic       busy, vrd, bfix;
        logic       adl_en, adh_en, db_en;
        logic [7:0] adl, adh, db;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   step_id = 0;

    // Model: PC as an integer, remaining vector bytes to fetch, pending PCH fix.
    int   m_pc, m_left, m_fix, m_base;
    bit   m_pend;

    function automatic stim_t nop();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    task automatic model_step(input stim_t s);
        int o, t;
        bit is_busy;
        is_busy = (m_left > 0) || (m_fix != 0);
        if (s.rst) begin
            m_pc = 0; m_left = 2; m_base = 'hFFFC; m_pend = 0; m_fix = 0;
        end else if (is_busy) begin
            if (s.vec_nmi) m_pend = 1;
            if (s.vec_rst) begin
                m_left = 2; m_base = 'hFFFC; m_fix = 0;
            end else if (m_left == 2) begin
                m_pc = (m_pc & 'hFF00) | int'(s.db); m_left = 1;
            end else if (m_left == 1) begin
                m_pc = (m_pc & 'h00FF) | (int'(s.db) << 8); m_left = 0;
            end else begin
                m_pc = ((((m_pc >> 8) + m_fix) & 'hFF) << 8) | (m_pc & 'hFF);
                m_fix = 0;
            end
        end else if (s.vec_rst) begin
            m_left = 2; m_base = 'hFFFC;
        end else if (m_pend || s.vec_nmi) begin
            m_left = 2; m_base = 'hFFFA; m_pend = 0;
        end else if (s.vec_irq) begin
            m_left = 2; m_base = 'hFFFE;
        end else if (s.adl_wa || s.adh_wa) begin
            if (s.adl_wa) m_pc = (m_pc & 'hFF00) | int'(s.adl);
            if (s.adh_wa) m_pc = (m_pc & 'h00FF) | (int'(s.adh) << 8);
        end else if (s.br_en) begin
            o = int'(s.off);
            if (o > 127) o = o - 256;
            t = (m_pc & 'hFF) + o;
            m_pc = (m_pc & 'hFF00) | (t & 'hFF);
            if (t < 0 || t > 255) m_fix = (o < 0) ? -1 : 1;
        end else if (s.pc_inc) begin
            m_pc = (m_pc + 1) & 'hFFFF;
        end
    endtask

    // Drive one cycle of inputs, record what the DUT must show during it, advance the model.
    task automatic apply(input stim_t s);
        exp_t e;
        @(posedge clk);
        #1;
        rst = s.rst; adl_wa = s.adl_wa; adh_wa = s.adh_wa; pc_inc = s.pc_inc;
        br_en = s.br_en; vec_rst = s.vec_rst; vec_nmi = s.vec_nmi; vec_irq = s.vec_irq;
        setstk = s.setstk; adloa = s.adloa; adhoa = s.adhoa; dboa_l = s.dboa_l; dboa_h = s.dboa_h;
        adl_in = s.adl; adh_in = s.adh; br_off = s.off; db_in = s.db;
        e.id     = step_id;
        e.pc     = 16'(m_pc);
        e.busy   = (m_left > 0) || (m_fix != 0);
        e.vrd    = (m_left > 0);
        e.vaddr  = (m_left > 0) ? 16'(m_base + 2 - m_left) : 16'h0000;
        e.bfix   = (m_fix != 0);
        e.adl_en = s.adloa;
        e.adl    = 8'(m_pc);
        e.adh_en = s.setstk || s.adhoa;
        e.adh    = s.setstk ? 8'h01 : 8'(m_pc >> 8);
        e.db_en  = s.dboa_l || s.dboa_h;
        e.db     = s.dboa_l ? 8'(m_pc) : 8'(m_pc >> 8);
        q.push_back(e);
        step_id++;
        model_step(s);
    endtask

    task automatic chk(input string name, input int id, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s step=%0d got=%h expected=%h", name, id, got, exp);
        end
    endtask

    exp_t me;
    always @(negedge clk) begin
        if (q.size() > 0) begin
            me = q.pop_front();
            chk("pc", me.id, pc, me.pc);
            chk("busy", me.id, 16'(busy), 16'(me.busy));
            chk("vec_rd", me.id, 16'(vec_rd), 16'(me.vrd));
            chk("vec_addr", me.id, vec_addr, me.vaddr);
            chk("br_fix", me.id, 16'(br_fix), 16'(me.bfix));
            if (me.adl_en) chk("adl_out", me.id, 16'(adl_out), 16'(me.adl));
            if (me.adh_en) chk("adh_out", me.id, 16'(adh_out), 16'(me.adh));
            if (me.db_en)  chk("db_out", me.id, 16'(db_out), 16'(me.db));
        end
    end

    task automatic load(input logic [15:0] v);
        stim_t s;
        s = nop(); s.adl_wa = 1; s.adh_wa = 1; s.adl = v[7:0]; s.adh = v[15:8];
        apply(s);
    endtask

    task automatic branch(input logic [7:0] off);
        stim_t s;
        s = nop(); s.br_en = 1; s.off = off;
        apply(s);
    endtask

    task automatic fetch_byte(input logic [7:0] d, input bit nmi, input bit r);
        stim_t s;
        s = nop(); s.db = d; s.vec_nmi = nmi; s.rst = r;
        apply(s);
    endtask

    initial begin
        stim_t s;
        rst = 1; adl_wa = 0; adh_wa = 0; pc_inc = 0; br_en = 0;
        vec_rst = 0; vec_nmi = 0; vec_irq = 0;
        setstk = 0; adloa = 0; adhoa = 0; dboa_l = 0; dboa_h = 0;
        adl_in = 0; adh_in = 0; br_off = 0; db_in = 0;
        m_pc = 0; m_left = 2; m_base = 'hFFFC; m_pend = 0; m_fix = 0;
        @(posedge clk);

        // Reset fetch of 16'h1234
        s = nop(); s.rst = 1; apply(s);
        fetch_byte(8'h34, 0, 0);
        fetch_byte(8'h12, 0, 0);
        apply(nop());

        // Increment carry, wrap, and load beating increment
        load(16'h12FF);
        s = nop(); s.pc_inc = 1; apply(s);
        load(16'hFFFF);
        s = nop(); s.pc_inc = 1; apply(s);
        s = nop(); s.adl_wa = 1; s.adl = 8'h55; s.pc_inc = 1; apply(s);
        apply(nop());

        // Branches: in-page, forward page cross, backward page cross
        load(16'h1210); branch(8'h05); apply(nop());
        load(16'h12F0); branch(8'h20); apply(nop()); apply(nop());
        load(16'h1205); branch(8'hF0); apply(nop()); apply(nop());

        // NMI raised during an IRQ fetch runs right after it
        s = nop(); s.vec_irq = 1; apply(s);
        fetch_byte(8'hAA, 0, 0);
        fetch_byte(8'hBB, 1, 0);
        apply(nop());
        fetch_byte(8'hCC, 0, 0);
        fetch_byte(8'hDD, 0, 0);
        apply(nop()); apply(nop());

        // Reset during the IRQ high-byte cycle restarts at the reset vector
        s = nop(); s.vec_irq = 1; apply(s);
        fetch_byte(8'h11, 0, 0);
        fetch_byte(8'h22, 0, 1);
        fetch_byte(8'h78, 0, 0);
        fetch_byte(8'h56, 0, 0);
        apply(nop());

        // Bus drivers
        load(16'hAB12);
        s = nop(); s.setstk = 1; s.adhoa = 1; apply(s);
        apply(nop());
        s = nop(); s.dboa_l = 1; s.dboa_h = 1; apply(s);
        s = nop(); s.dboa_h = 1; s.adloa = 1; s.adhoa = 1; apply(s);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            s.rst     = ($urandom_range(149) == 0);
            s.vec_rst = ($urandom_range(59) == 0);
            s.vec_nmi = ($urandom_range(29) == 0);
            s.vec_irq = ($urandom_range(29) == 0);
            s.adl_wa  = ($urandom_range(7) == 0);
            s.adh_wa  = ($urandom_range(7) == 0);
            s.br_en   = ($urandom_range(4) == 0);
            s.pc_inc  = ($urandom_range(1) == 0);
            s.setstk  = 1'($urandom);
            s.adloa   = 1'($urandom);
            s.adhoa   = 1'($urandom);
            s.dboa_l  = 1'($urandom);
            s.dboa_h  = 1'($urandom);
            s.adl     = 8'($urandom);
            s.adh     = 8'($urandom);
            s.off     = 8'($urandom);
            s.db      = 8'($urandom);
            apply(s);
        end

        apply(nop());
        for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending=%0d expected=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Full program counter for the 6502 datapath, combining the low and high PC bytes in one block with parametrised address and data widths.
Adds behaviour the split PC registers lack:
- internal vector-fetch sequencer for RESET/NMI/IRQ, which reads the vector bytes itself
- relative-branch adder with page-cross fixup cycle
- pending-NMI latch
Sits between the ADL/ADH/DB buses and the instruction decoder.

Parameters:
AW, 16, total PC width in bits
DW, 8, data-bus width and PCL width; PCH width is AW-DW
VEC_NMI, 16'hFFFA, NMI vector low-byte address
VEC_RST, 16'hFFFC, RESET vector low-byte address
VEC_IRQ, 16'hFFFE, IRQ vector low-byte address
STK_PAGE, 8'h01, value forced onto ADH for stack access (width AW-DW)

Ports:
clk  in  1  clock; all state changes on posedge
rst  in  1  synchronous active-high reset
adl_in  in  DW  ADL bus input
adh_in  in  AW-DW  ADH bus input
adl_wa  in  1  load PCL from adl_in
adh_wa  in  1  load PCH from adh_in
pc_inc  in  1  increment PC
br_en  in  1  apply relative branch
br_off  in  DW  two's-complement branch offset
vec_rst  in  1  request RESET vector fetch
vec_nmi  in  1  request NMI vector fetch
vec_irq  in  1  request IRQ vector fetch
db_in  in  DW  data bus read data, used during vector fetch
setstk  in  1  drive STK_PAGE on adh_out
adloa  in  1  drive PCL on adl_out
adhoa  in  1  drive PCH on adh_out
dboa_l  in  1  drive PCL on db_out
dboa_h  in  1  drive PCH on db_out
adl_out  out  DW  tristate ADL driver
adh_out  out  AW-DW  tristate ADH driver
db_out  out  DW  tristate DB driver
pc  out  AW  current PC {PCH,PCL}
vec_addr  out  AW  vector-fetch address
vec_rd  out  1  vector read strobe
busy  out  1  state != IDLE
br_fix  out  1  high during page-cross fixup cycle

Behaviour:
States: IDLE, VEC_LO, VEC_HI, BR_FIX.

Reset (rst=1, overrides everything, any state):
- pc=0, state=VEC_LO, vsel=RST, nmi_pend=0
- Holding rst keeps state in VEC_LO with no capture.
- Outputs during and after reset: busy=1, vec_rd=1, vec_addr=VEC_RST, br_fix=0.

Vector fetch:
- VEC_LO: vec_rd=1, vec_addr=vector base. Capture db_in into PCL, go to VEC_HI.
- VEC_HI: vec_rd=1, vec_addr=base+1. Capture db_in into PCH, go to IDLE.
- Latency: request sampled in IDLE at cycle n; PC holds the vector at n+3.
- vec_rd=0 and vec_addr=0 in IDLE and BR_FIX.

IDLE priority, highest first:
1. vec_rst
2. nmi_pend or vec_nmi
3. vec_irq
4. adl_wa/adh_wa
5. br_en
6. pc_inc
- Lower items are ignored in the same cycle.
- Entering an NMI fetch clears nmi_pend.

Loads:
- adl_wa and adh_wa are independent; both together load the full PC.
- A load suppresses pc_inc/br_en in that cycle.

Increment:
- pc <= pc+1 mod 2^AW; carry from PCL propagates into PCH.
- 16'hFFFF -> 16'h0000.

Branch:
- sum = PCL + br_off, with br_off sign-extended to DW+1 bits.
- If no carry/borrow: PCL updated, one cycle, state stays IDLE.
- Else: PCL <= sum[DW-1:0] and go to BR_FIX.
- In BR_FIX: br_fix=1, PCH +/-1 mod 2^(AW-DW), then return to IDLE.

While busy:
- All inputs are ignored except the following.
- vec_rst restarts at VEC_LO with vsel=RST; nmi_pend is kept.
- vec_nmi sets nmi_pend.
- vec_irq is dropped.

Bus drivers (combinational; z when not enabled):
- adh_out: setstk beats adhoa, so both asserted gives STK_PAGE (single driver).
- db_out: dboa_l beats dboa_h.
- Drivers are valid in any state.

Test Plan:
- Reset fetch: rst 1 cycle; db_in=8'h34 in VEC_LO, 8'h12 in VEC_HI -> vec_addr FFFC then FFFD, vec_rd=1 both cycles, pc=16'h1234 and busy=0 on third cycle.
- Increment carry/wrap: pc=16'h12FF + pc_inc -> 16'h1300; pc=16'hFFFF + pc_inc -> 16'h0000; adl_wa+pc_inc same cycle -> load only.
- Branches:
  - pc=16'h1210, off=8'h05 -> 16'h1215 in one cycle, br_fix=0.
  - pc=16'h12F0, off=8'h20 -> 16'h1210 with br_fix=1, then 16'h1310.
  - pc=16'h1205, off=8'hF0 -> 16'h11F5 after two cycles.
- NMI pending: pulse vec_nmi during VEC_HI of an IRQ fetch -> IRQ completes, then NMI fetch from FFFA/FFFB, nmi_pend cleared.
- Reset mid-fetch: vec_irq, then rst during VEC_HI -> fetch restarts at VEC_LO, vec_addr=FFFC, PCH not written from the IRQ fetch.
- Buses: setstk=adhoa=1 -> adh_out=8'h01; no enables -> all outputs z; dboa_l=dboa_h=1 with pc=16'hAB12 -> db_out=8'h12.
